// File: rtl/dtc_share_arbiter.sv
// Round-robin sequencer sharing one combinational decision-tree classifier among NREQ requesters.
// Optional per-requester saturating grant counters are built when DTC_ARB_PERF_EN is defined.
module dtc_share_arbiter #(
    parameter int NREQ  = 4,
    parameter int IN_W  = 8,
    parameter int OUT_W = 63,
    parameter int CNT_W = 16,
    localparam int ID_W = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*IN_W-1:0] req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic [IN_W-1:0]      tree_inp,
    input  logic [OUT_W-1:0]     tree_outp,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [OUT_W-1:0]     rsp_data,
    output logic [ID_W-1:0]      rsp_id,
    output logic                 busy
`ifdef DTC_ARB_PERF_EN
    ,
    output logic [NREQ*CNT_W-1:0] grant_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, EVAL, HOLD} state_t;

    state_t          state_q, state_d;
    logic [ID_W-1:0] ptr, id_reg, winner;
    logic [IN_W-1:0] op_reg;
    logic            found, window, accept;

    assign window = (state_q == IDLE) || (state_q == HOLD && rsp_ready);

    // First valid requester at or after ptr, wrapping modulo NREQ.
    always_comb begin
        int idx;
        // NOTE: every variable written here gets a default first, otherwise a latch is inferred.
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                winner = ID_W'(idx);
            end
        end
    end

    assign accept = window && found && !rst;

    always_comb begin
        req_ready = '0;
        if (accept) req_ready[winner] = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = EVAL;
            EVAL:    state_d = HOLD;
            HOLD:    if (accept) state_d = EVAL;
                     else if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr      <= '0;
            id_reg   <= '0;
            op_reg   <= '0;
            rsp_data <= '0;
            rsp_id   <= '0;
        end else begin
            if (accept) begin
                op_reg <= req_data[winner*IN_W +: IN_W];
                id_reg <= winner;
                ptr    <= (winner == ID_W'(NREQ - 1)) ? '0 : winner + 1'b1;
            end
            // The tree has had one full cycle to settle on op_reg.
            if (state_q == EVAL) begin
                rsp_data <= tree_outp;
                rsp_id   <= id_reg;
            end
        end
    end

    assign tree_inp  = op_reg;
    assign rsp_valid = (state_q == HOLD);
    assign busy      = (state_q != IDLE);

`ifdef DTC_ARB_PERF_EN
    logic [NREQ-1:0][CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (accept && cnt_q[winner] != '1) begin
            cnt_q[winner] <= cnt_q[winner] + 1'b1;
        end
    end

    assign grant_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_dtc_share_arbiter.sv
// Scoreboard bench for dtc_share_arbiter: a cycle model predicts grants and queues expected results.
module tb_dtc_share_arbiter;
    localparam int NREQ  = 4;
    localparam int IN_W  = 8;
    localparam int OUT_W = 63;
`ifdef DTC_ARB_PERF_EN
    localparam int CNT_W = 2;
`else
    localparam int CNT_W = 16;
`endif

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NREQ-1:0]      req_valid = '0;
    logic [NREQ*IN_W-1:0] req_data = '0;
    logic [NREQ-1:0]      req_ready;
    logic [IN_W-1:0]      tree_inp;
    logic [OUT_W-1:0]     tree_outp;
    logic                 rsp_valid;
    logic                 rsp_ready = 1'b1;
    logic [OUT_W-1:0]     rsp_data;
    logic [1:0]           rsp_id;
    logic                 busy;
`ifdef DTC_ARB_PERF_EN
    logic [NREQ*CNT_W-1:0] grant_cnt;
`endif

    always #5 clk = ~clk;

    // Stand-in classifier: an arbitrary but input-sensitive mapping.
    function automatic logic [OUT_W-1:0] tree_f(input logic [7:0] x);
        return {x ^ 8'h3C, x + 8'h11, ~x, {x[3:0], x[7:4]}, x ^ 8'hA5,
                x - 8'h07, 8'h5A ^ {x[0], x[7:1]}, x[6:0]};
    endfunction

    assign tree_outp = tree_f(tree_inp);

    dtc_share_arbiter #(.NREQ(NREQ), .IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .tree_inp(tree_inp), .tree_outp(tree_outp),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy)
`ifdef DTC_ARB_PERF_EN
        , .grant_cnt(grant_cnt)
`endif
    );

    typedef struct packed {
        logic [1:0]       id;
        logic [OUT_W-1:0] data;
    } rsp_t;

    rsp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   m_state  = 0;   // 0 idle, 1 eval, 2 hold
    int   m_ptr    = 0;
    int   m_cnt[NREQ];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_ptr   = 0;
        sb.delete();
        for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
    endtask

    // One clock: check outputs mid-cycle, predict, then advance past the edge.
    task automatic step();
        bit         win;
        int         w, nstate, nptr;
        logic [3:0] exp_ready;
        @(negedge clk);
        win = 0; w = 0; exp_ready = '0;
        if (!rst && (m_state == 0 || (m_state == 2 && rsp_ready))) begin
            for (int k = 0; k < NREQ; k++) begin
                if (!win && req_valid[(m_ptr + k) % NREQ]) begin
                    win = 1;
                    w   = (m_ptr + k) % NREQ;
                end
            end
        end
        if (win) exp_ready[w] = 1'b1;
        check("req_ready", 64'(req_ready), 64'(exp_ready));
        check("rsp_valid", 64'(rsp_valid), 64'(m_state == 2));
        check("busy", 64'(busy), 64'(m_state != 0));
`ifdef DTC_ARB_PERF_EN
        for (int i = 0; i < NREQ; i++)
            check("grant_cnt_i", 64'(grant_cnt[i*CNT_W +: CNT_W]), 64'(m_cnt[i]));
`endif
        if (rsp_valid) begin
            if (sb.size() == 0) begin
                check("rsp_unexpected", 64'(rsp_valid), 64'(0));
            end else begin
                check("rsp_id", 64'(rsp_id), 64'(sb[0].id));
                check("rsp_data", 64'(rsp_data), 64'(sb[0].data));
                if (rsp_ready && !rst) void'(sb.pop_front());
            end
        end
        nstate = m_state;
        nptr   = m_ptr;
        if (rst) begin
            model_reset();
            nstate = 0;
            nptr   = 0;
        end else if (win) begin
            sb.push_back('{id: 2'(w), data: tree_f(req_data[w*IN_W +: IN_W])});
            nptr   = (w + 1) % NREQ;
            nstate = 1;
            if (m_cnt[w] < (1 << CNT_W) - 1) m_cnt[w]++;
        end else if (m_state == 1) begin
            nstate = 2;
        end else if (m_state == 2 && rsp_ready) begin
            nstate = 0;
        end
        @(posedge clk);
        m_state = nstate;
        m_ptr   = nptr;
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        model_reset();
        // Reset state
        rst = 1'b1;
        steps(2);
        rst = 1'b0;
        check("tree_inp_rst", 64'(tree_inp), 64'(0));
        check("rsp_data_rst", 64'(rsp_data), 64'(0));
        check("rsp_id_rst", 64'(rsp_id), 64'(0));
        step();

        // Single request from requester 2 with 8'hA5
        req_data  = {8'h11, 8'hA5, 8'h22, 8'h33};
        req_valid = 4'b0100;
        step();
        req_valid = 4'b0000;
        check("tree_inp_a5", 64'(tree_inp), 64'(8'hA5));
        steps(3);

        // Wrap from ptr 3 with sparse requests: 0 then 1
        req_data  = {8'h44, 8'h55, 8'h66, 8'h77};
        req_valid = 4'b0011;
        step();
        req_valid = 4'b0000;
        steps(3);
        req_valid = 4'b0011;
        step();
        req_valid = 4'b0000;
        steps(3);

        // Fairness: everyone valid, consumer always ready
        rst = 1'b1;
        step();
        rst = 1'b0;
        req_valid = 4'b1111;
        for (int i = 0; i < 12; i++) begin
            req_data = $urandom;
            step();
        end

        // Backpressure while holding a result
        for (int i = 0; i < 4 && m_state != 2; i++) step();
        rsp_ready = 1'b0;
        steps(5);
        rsp_ready = 1'b1;
        step();
        req_valid = 4'b0000;
        steps(4);

        // Reset while in EVAL discards the transaction
        req_valid = 4'b0100;
        step();
        req_valid = 4'b0000;
        rst = 1'b1;
        step();
        rst = 1'b0;
        steps(4);
        req_valid = 4'b1111;
        step();
        req_valid = 4'b0000;
        steps(3);

        // Randomised traffic with random backpressure
        for (int i = 0; i < 300; i++) begin
            req_valid = 4'($urandom);
            req_data  = $urandom;
            rsp_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        req_valid = 4'b0000;
        rsp_ready = 1'b1;
        steps(4);
        check("sb_drained", 64'(sb.size()), 64'(0));

`ifdef DTC_ARB_PERF_EN
        // Counter saturation: five accepts from requester 1
        rst = 1'b1;
        step();
        rst = 1'b0;
        req_valid = 4'b0010;
        steps(10);
        req_valid = 4'b0000;
        steps(3);
        check("grant_cnt_sat", 64'(grant_cnt), 64'({2'd0, 2'd0, 2'd3, 2'd0}));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
